oled_framebuffer: RTL and testbench

OLED_FRAMEBUFFER -- requirements
Module: oled_framebuffer

---
 rtl/oled_framebuffer_if.sv | 37 +++
 rtl/oled_framebuffer.sv | 108 ++++++++++
 tb/tb_oled_framebuffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/oled_framebuffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_framebuffer_if : display read port, host write port and clear control
// rev 1.0
// ---------------------------------------------------------------------------
interface oled_framebuffer_if;
   logic       read;
   logic [2:0] page_idx;
   logic [6:0] column_idx;
   logic [7:0] data;
   logic       ack;

   logic       wr_en;
   logic [2:0] wr_page;
   logic [6:0] wr_column;
   logic [7:0] wr_data;
   logic       wr_ack;

   logic       clear;
   logic [7:0] clear_data;
   logic       busy;

   modport master (
      output read, page_idx, column_idx,
      output wr_en, wr_page, wr_column, wr_data,
      output clear, clear_data,
      input  data, ack, wr_ack, busy
   );

   modport slave (
      input  read, page_idx, column_idx,
      input  wr_en, wr_page, wr_column, wr_data,
      input  clear, clear_data,
      output data, ack, wr_ack, busy
   );
endinterface
`default_nettype wire

// File: rtl/oled_framebuffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_framebuffer : 8 x 128 byte OLED frame store with bulk fill engine
// rev 1.0
// ---------------------------------------------------------------------------
module oled_framebuffer (
   input  logic                clk,
   input  logic                resetn,
   oled_framebuffer_if.slave   bus
);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   localparam int          DEPTH     = 1024;
   localparam logic [9:0]  LAST_ADDR = 10'd1023;

   state_t     state_q, state_d;
   logic [9:0] fill_addr_q, fill_addr_d;
   logic [7:0] fill_val_q, fill_val_d;

   logic [7:0] data_q;
   logic       ack_q;
   logic       wr_ack_q;
   logic       wr_accept;

   logic [9:0] rd_addr;
   logic [9:0] wr_addr;

   logic [7:0] mem [0:DEPTH-1];

   assign rd_addr = {bus.page_idx, bus.column_idx};
   assign wr_addr = {bus.wr_page, bus.wr_column};

   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      fill_val_d  = fill_val_q;
      wr_accept   = 1'b0;
      case (state_q)
         ST_FILL: begin
            // Counter rolls 1023 -> 0 naturally on the exit cycle.
            fill_addr_d = fill_addr_q + 10'd1;
            if (fill_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.clear) begin
               fill_val_d  = bus.clear_data;
               fill_addr_d = 10'd0;
               state_d     = ST_FILL;
            end else begin
               wr_accept = bus.wr_en;
            end
         end
         default: begin
            state_d     = ST_FILL;
            fill_addr_d = 10'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_FILL;
         fill_addr_q <= 10'd0;
         fill_val_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         fill_val_q  <= fill_val_d;
      end
   end

   // Storage carries no reset; the post-reset fill initialises every byte.
   always_ff @(posedge clk) begin
      if (state_q == ST_FILL) begin
         mem[fill_addr_q] <= fill_val_q;
      end else if (wr_accept) begin
         mem[wr_addr] <= bus.wr_data;
      end
   end

   // While filling, reads return the fill byte so no half-cleared frame shows.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q   <= 8'h00;
         ack_q    <= 1'b0;
         wr_ack_q <= 1'b0;
      end else begin
         ack_q    <= bus.read;
         wr_ack_q <= wr_accept;
         if (bus.read) begin
            data_q <= (state_q == ST_FILL) ? fill_val_q : mem[rd_addr];
         end
      end
   end

   assign bus.data   = data_q;
   assign bus.ack    = ack_q;
   assign bus.wr_ack = wr_ack_q;
   assign bus.busy   = (state_q == ST_FILL);

endmodule
`default_nettype wire

// File: tb/tb_oled_framebuffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_oled_framebuffer : directed self-checking bench for oled_framebuffer
// rev 1.0
// ---------------------------------------------------------------------------
module tb_oled_framebuffer;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_errors;
   int   n;

   oled_framebuffer_if fb ();

   oled_framebuffer dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (fb.busy && cnt < 5000) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic read_all(input logic [7:0] expv, input string tag);
      for (int k = 0; k <= 1024; k++) begin
         if (k > 0) begin
            check({tag, "_ack"}, {31'd0, fb.ack}, 32'd1);
            check({tag, "_data"}, {24'd0, fb.data}, {24'd0, expv});
         end
         fb.read = (k < 1024);
         {fb.page_idx, fb.column_idx} = k[9:0];
         @(negedge clk);
      end
      check({tag, "_ack_end"}, {31'd0, fb.ack}, 32'd0);
   endtask

   task automatic read_one(input logic [2:0] pg, input logic [6:0] col,
                           input logic [7:0] expv, input string tag);
      fb.read       = 1'b1;
      fb.page_idx   = pg;
      fb.column_idx = col;
      @(negedge clk);
      fb.read = 1'b0;
      check({tag, "_ack"}, {31'd0, fb.ack}, 32'd1);
      check({tag, "_data"}, {24'd0, fb.data}, {24'd0, expv});
      @(negedge clk);
      check({tag, "_ack_low"}, {31'd0, fb.ack}, 32'd0);
      check({tag, "_hold"}, {24'd0, fb.data}, {24'd0, expv});
   endtask

   task automatic write_byte(input logic [2:0] pg, input logic [6:0] col,
                             input logic [7:0] val, input string tag);
      fb.wr_en     = 1'b1;
      fb.wr_page   = pg;
      fb.wr_column = col;
      fb.wr_data   = val;
      @(negedge clk);
      fb.wr_en = 1'b0;
      check({tag, "_wr_ack"}, {31'd0, fb.wr_ack}, 32'd1);
      @(negedge clk);
      check({tag, "_wr_ack_low"}, {31'd0, fb.wr_ack}, 32'd0);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      resetn        = 1'b0;
      fb.read       = 1'b0;
      fb.page_idx   = 3'd0;
      fb.column_idx = 7'd0;
      fb.wr_en      = 1'b0;
      fb.wr_page    = 3'd0;
      fb.wr_column  = 7'd0;
      fb.wr_data    = 8'h00;
      fb.clear      = 1'b0;
      fb.clear_data = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_busy",   {31'd0, fb.busy},   32'd1);
      check("rst_ack",    {31'd0, fb.ack},    32'd0);
      check("rst_wr_ack", {31'd0, fb.wr_ack}, 32'd0);
      check("rst_data",   {24'd0, fb.data},   32'd0);

      // Post-reset fill: 1024 busy cycles, then everything reads 0x00
      resetn = 1'b1;
      count_busy(n);
      check("init_busy_cycles", n, 32'd1024);
      read_all(8'h00, "init");

      // Single write and neighbour read
      write_byte(3'd3, 7'd77, 8'hA5, "wr_3_77");
      read_one(3'd3, 7'd77, 8'hA5, "rd_3_77");
      read_one(3'd3, 7'd76, 8'h00, "rd_3_76");

      // Full-rate reads while the host writes every cycle
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            check("stream_ack",    {31'd0, fb.ack},    32'd1);
            check("stream_data",   {24'd0, fb.data},   32'h0000_00A5);
            check("stream_wr_ack", {31'd0, fb.wr_ack}, 32'd1);
         end
         fb.read       = (k < 16);
         fb.page_idx   = 3'd3;
         fb.column_idx = 7'd77;
         fb.wr_en      = (k < 16);
         fb.wr_page    = 3'd2;
         fb.wr_column  = k[6:0];
         fb.wr_data    = 8'h40 + k[7:0];
         @(negedge clk);
      end
      check("stream_ack_end",    {31'd0, fb.ack},    32'd0);
      check("stream_wr_ack_end", {31'd0, fb.wr_ack}, 32'd0);
      read_one(3'd2, 7'd5,  8'h45, "rd_2_5");
      read_one(3'd2, 7'd15, 8'h4F, "rd_2_15");

      // Clear to 0xFF; a write coinciding with clear is dropped
      fb.clear      = 1'b1;
      fb.clear_data = 8'hFF;
      fb.wr_en      = 1'b1;
      fb.wr_page    = 3'd0;
      fb.wr_column  = 7'd0;
      fb.wr_data    = 8'h55;
      @(negedge clk);
      fb.clear = 1'b0;
      fb.wr_en = 1'b0;
      check("clr_wr_ack", {31'd0, fb.wr_ack}, 32'd0);
      check("clr_busy",   {31'd0, fb.busy},   32'd1);
      n = 0;
      while (fb.busy && n < 5000) begin
         n++;
         fb.clear      = (n == 100);
         fb.clear_data = (n == 100) ? 8'h11 : 8'hFF;
         fb.wr_en      = (n == 200);
         fb.wr_page    = 3'd3;
         fb.wr_column  = 7'd77;
         fb.wr_data    = 8'h22;
         fb.read       = (n == 300);
         fb.page_idx   = 3'd5;
         fb.column_idx = 7'd9;
         if (n == 201) check("fill_wr_ack", {31'd0, fb.wr_ack}, 32'd0);
         if (n == 301) begin
            check("fill_rd_ack",  {31'd0, fb.ack},  32'd1);
            check("fill_rd_data", {24'd0, fb.data}, 32'h0000_00FF);
         end
         @(negedge clk);
      end
      check("clr_busy_cycles", n, 32'd1024);
      read_all(8'hFF, "clrff");

      // Reset in the middle of a clear
      fb.clear      = 1'b1;
      fb.clear_data = 8'hFF;
      @(negedge clk);
      fb.clear = 1'b0;
      repeat (499) @(negedge clk);
      fb.read       = 1'b1;
      fb.page_idx   = 3'd5;
      fb.column_idx = 7'd9;
      @(negedge clk);
      check("mid_ack_pending", {31'd0, fb.ack}, 32'd1);
      resetn  = 1'b0;
      fb.read = 1'b0;
      #1;
      check("mid_rst_ack",    {31'd0, fb.ack},    32'd0);
      check("mid_rst_data",   {24'd0, fb.data},   32'd0);
      check("mid_rst_busy",   {31'd0, fb.busy},   32'd1);
      check("mid_rst_wr_ack", {31'd0, fb.wr_ack}, 32'd0);
      repeat (3) @(negedge clk);
      // A write presented on the release cycle lands in FILL and is dropped
      resetn       = 1'b1;
      fb.wr_en     = 1'b1;
      fb.wr_page   = 3'd1;
      fb.wr_column = 7'd1;
      fb.wr_data   = 8'h77;
      @(negedge clk);
      fb.wr_en = 1'b0;
      check("rel_wr_ack", {31'd0, fb.wr_ack}, 32'd0);
      count_busy(n);
      check("rel_busy_cycles", n, 32'd1023);
      read_all(8'h00, "rst00");

      // Same-cycle read and write to page 0 column 0
      fb.read       = 1'b1;
      fb.page_idx   = 3'd0;
      fb.column_idx = 7'd0;
      fb.wr_en      = 1'b1;
      fb.wr_page    = 3'd0;
      fb.wr_column  = 7'd0;
      fb.wr_data    = 8'h3C;
      @(negedge clk);
      fb.read  = 1'b0;
      fb.wr_en = 1'b0;
      check("rbw_ack",    {31'd0, fb.ack},    32'd1);
      check("rbw_data",   {24'd0, fb.data},   32'd0);
      check("rbw_wr_ack", {31'd0, fb.wr_ack}, 32'd1);
      @(negedge clk);
      read_one(3'd0, 7'd0, 8'h3C, "rbw_new");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
